// File: rtl/red_pitaya_dac_slew.sv
//------------------------------------------------------------------------------
// red_pitaya_dac_slew
//
// Output conditioning for one ASG channel, placed between the channel output
// and the DAC output register. It limits how far the DAC code can move in one
// cycle to a programmable step. It also provides a soft mute: the output ramps
// to mid-scale (code 0) and holds there, then ramps back to the live waveform.
// Channel reset, re-arm or output disable therefore never produce a full-scale
// step at the analog output.
//
// Ports
//   dac_clk_i   DAC clock
//   dac_rstn_i  asynchronous active-low reset
//   dat_i       signed sample from the ASG channel, valid every cycle
//   set_rate_i  unsigned maximum step per cycle in LSB; 0 bypasses the limiter
//   set_mute_i  level: 1 = ramp to 0 and hold, 0 = return to dat_i
//   dac_o       signed limited output (registered)
//   busy_o      output is still being step-limited (output != target)
//   muted_o     output is parked at exactly 0 in the MUTED state
//------------------------------------------------------------------------------
module red_pitaya_dac_slew #(
   parameter int DW = 14
) (
   input  logic                 dac_clk_i,
   input  logic                 dac_rstn_i,
   input  logic signed [DW-1:0] dat_i,
   input  logic        [DW-1:0] set_rate_i,
   input  logic                 set_mute_i,
   output logic signed [DW-1:0] dac_o,
   output logic                 busy_o,
   output logic                 muted_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUTING   = 2'd1,
      MUTED    = 2'd2,
      UNMUTING = 2'd3
   } state_t;

   state_t             state;
   state_t             mode;       // state that governs this cycle's update
   state_t             state_nxt;

   logic [DW-1:0]      dat_q;
   logic [DW-1:0]      tgt;
   logic [DW:0]        diff;
   logic [DW-1:0]      mag;
   logic [DW-1:0]      dac_nxt;

   //---------------------------------------------------------------------------
   // set_mute_i is not registered. Its effect on the target must appear in the
   // same edge that it is sampled, so the first ramp step shows up one cycle
   // after the request. The update therefore uses the state this edge is
   // moving into, not the state currently held.
   //---------------------------------------------------------------------------
   always_comb begin
      mode = state;
      case (state)
         RUN:      if (set_mute_i)  mode = MUTING;
         MUTING:   if (!set_mute_i) mode = UNMUTING;
         MUTED:    if (!set_mute_i) mode = UNMUTING;
         UNMUTING: if (set_mute_i)  mode = MUTING;
         default:  mode = RUN;
      endcase
   end

   assign tgt = ((mode == MUTING) || (mode == MUTED)) ? '0 : dat_q;

   //---------------------------------------------------------------------------
   // Slew arithmetic. The difference is computed one bit wider so a full
   // -8192 .. 8191 swing cannot overflow. Its magnitude still fits in DW bits
   // unsigned, because the low DW bits of the negation are exact.
   //---------------------------------------------------------------------------
   assign diff = {tgt[DW-1], tgt} - {dac_o[DW-1], dac_o};
   assign mag  = diff[DW] ? (~diff[DW-1:0] + 1'b1) : diff[DW-1:0];

   // A limited step always lands strictly between dac_o and tgt. The DW-bit
   // wrap-around sum is therefore the true result, and no saturation is needed.
   always_comb begin
      if ((set_rate_i == '0) || (mag <= set_rate_i))
         dac_nxt = tgt;
      else if (diff[DW])
         dac_nxt = dac_o - set_rate_i;
      else
         dac_nxt = dac_o + set_rate_i;
   end

   // Settling decisions look at the value being loaded this edge. This keeps
   // the state, dac_o, busy_o and muted_o mutually consistent.
   always_comb begin
      state_nxt = mode;
      case (mode)
         MUTING:   if (dac_nxt == '0)   state_nxt = MUTED;
         UNMUTING: if (dac_nxt == dat_q) state_nxt = RUN;
         default:  state_nxt = mode;
      endcase
   end

   //---------------------------------------------------------------------------
   // State, output and status registers
   //---------------------------------------------------------------------------
   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         state   <= RUN;
         dat_q   <= '0;
         dac_o   <= '0;
         busy_o  <= 1'b0;
         muted_o <= 1'b0;
      end else begin
         state   <= state_nxt;
         dat_q   <= dat_i;
         dac_o   <= dac_nxt;
         busy_o  <= (dac_nxt != tgt);
         muted_o <= (state_nxt == MUTED);
      end
   end

endmodule
